ps2_wasd_receiver: RTL and testbench

//   PS/2 keyboard receiver that produces the active-low w/a/s/d movement inputs for the PacMan top level.
//   - Samples the device-driven ps2_clk/ps2_data lines and assembles 11-bit frames.
//   - Decodes scan-code set 2 make/break sequences into level-held key outputs.
//   - Sits between the board PS/2 connector and the PacMan w/a/s/d inputs, replacing the push buttons.

---
 rtl/ps2_wasd_receiver.sv | 265 ++++++++++++++++++++++++++
 tb/tb_ps2_wasd_receiver.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_wasd_receiver.sv
`default_nettype none
// ============================================================================
// Module   : ps2_wasd_receiver
// Purpose  : PS/2 keyboard receiver that turns scan-code set 2 make/break
//            sequences into the active-low w/a/s/d movement inputs of the
//            PacMan top level. Receive only: ps2_clk/ps2_data are never driven.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   SYNC_STAGES     synchroniser depth on ps2_clk and ps2_data (>= 2)
//   TIMEOUT_CYCLES  clk cycles without a ps2_clk fall before a partial frame
//                   is aborted
// Ports
//   clk         in   system clock, all logic on posedge
//   reset       in   asynchronous, active-low reset
//   ps2_clk     in   PS/2 clock from device (asynchronous, idle high)
//   ps2_data    in   PS/2 data from device (asynchronous, idle high)
//   w, a, s, d  out  active-low key levels, 0 while the key is held
//   key_valid   out  one-cycle pulse, a good frame was received
//   key_code    out  last good byte, held between pulses
//   parity_err  out  one-cycle pulse, frame failed parity or stop check
// Configuration
//   PS2_ARROW_KEYS_EN  when defined, extended arrow codes E0 75/6B/72/74 also
//                      drive w/a/s/d; otherwise extended bytes are ignored.
// ============================================================================
module ps2_wasd_receiver #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       w,
  output logic       a,
  output logic       s,
  output logic       d,
  output logic       key_valid,
  output logic [7:0] key_code,
  output logic       parity_err
);

  localparam int c_TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(TIMEOUT_CYCLES - 1);

  localparam logic [7:0] c_BREAK    = 8'hF0;
  localparam logic [7:0] c_EXTENDED = 8'hE0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // Synchronisers: reset to 1 so releasing reset never looks like a clk fall.
  // --------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] r_clk_sync;
  logic [SYNC_STAGES-1:0] r_data_sync;
  logic                   r_clk_prev;
  logic                   w_clk_s;
  logic                   w_data_s;
  logic                   w_fall;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_clk_sync  <= '1;
      r_data_sync <= '1;
      r_clk_prev  <= 1'b1;
    end else begin
      r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0], ps2_clk};
      r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], ps2_data};
      r_clk_prev  <= w_clk_s;
    end
  end

  assign w_clk_s  = r_clk_sync[SYNC_STAGES-1];
  assign w_data_s = r_data_sync[SYNC_STAGES-1];
  assign w_fall   = r_clk_prev & ~w_clk_s;

  // --------------------------------------------------------------------------
  // Frame FSM
  // --------------------------------------------------------------------------
  state_t              r_state;
  state_t              w_state_nxt;
  logic [2:0]          r_bit_cnt;
  logic [2:0]          w_bit_cnt_nxt;
  logic [7:0]          r_shift;
  logic [7:0]          w_shift_nxt;
  logic                r_parity;
  logic                w_parity_nxt;
  logic [c_TO_W-1:0]   r_to_cnt;
  logic [c_TO_W-1:0]   w_to_cnt_nxt;
  logic                w_timeout;
  logic                w_frame_done;
  logic                w_frame_good;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_bit_cnt <= 3'd0;
      r_shift   <= 8'h00;
      r_parity  <= 1'b0;
      r_to_cnt  <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_shift   <= w_shift_nxt;
      r_parity  <= w_parity_nxt;
      r_to_cnt  <= w_to_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_bit_cnt_nxt = r_bit_cnt;
    w_shift_nxt   = r_shift;
    w_parity_nxt  = r_parity;
    w_to_cnt_nxt  = r_to_cnt;
    w_timeout     = 1'b0;
    w_frame_done  = 1'b0;
    // Odd parity over byte+parity bit, and the stop bit must be high.
    w_frame_good  = (^r_shift ^ r_parity) & w_data_s;

    // The watchdog only runs mid-frame; any fall restarts it.
    if (r_state == ST_IDLE || w_fall) begin
      w_to_cnt_nxt = '0;
    end else if (r_to_cnt == c_TO_LAST) begin
      w_timeout    = 1'b1;
      w_to_cnt_nxt = '0;
      w_state_nxt  = ST_IDLE;
      w_shift_nxt  = 8'h00;
    end else begin
      w_to_cnt_nxt = r_to_cnt + 1'b1;
    end

    if (w_fall) begin
      unique case (r_state)
        ST_IDLE: begin
          // A high level here is a glitch, not a start bit.
          if (!w_data_s) begin
            w_state_nxt   = ST_DATA;
            w_bit_cnt_nxt = 3'd0;
          end
        end
        ST_DATA: begin
          w_shift_nxt   = {w_data_s, r_shift[7:1]};
          w_bit_cnt_nxt = r_bit_cnt + 3'd1;
          if (r_bit_cnt == 3'd7) begin
            w_state_nxt = ST_PARITY;
          end
        end
        ST_PARITY: begin
          w_parity_nxt = w_data_s;
          w_state_nxt  = ST_STOP;
        end
        ST_STOP: begin
          w_frame_done = 1'b1;
          w_state_nxt  = ST_IDLE;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Scan-code decoder. Keys are stored active-low {w, a, s, d}.
  // --------------------------------------------------------------------------
  logic       r_key_valid;
  logic       w_key_valid_nxt;
  logic       r_parity_err;
  logic       w_parity_err_nxt;
  logic [7:0] r_key_code;
  logic [7:0] w_key_code_nxt;
  logic       r_break;
  logic       w_break_nxt;
  logic       r_ext;
  logic       w_ext_nxt;
  logic [3:0] r_keys;
  logic [3:0] w_keys_nxt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_key_valid  <= 1'b0;
      r_parity_err <= 1'b0;
      r_key_code   <= 8'h00;
      r_break      <= 1'b0;
      r_ext        <= 1'b0;
      r_keys       <= 4'hF;
    end else begin
      r_key_valid  <= w_key_valid_nxt;
      r_parity_err <= w_parity_err_nxt;
      r_key_code   <= w_key_code_nxt;
      r_break      <= w_break_nxt;
      r_ext        <= w_ext_nxt;
      r_keys       <= w_keys_nxt;
    end
  end

  always_comb begin
    w_key_valid_nxt  = 1'b0;
    w_parity_err_nxt = 1'b0;
    w_key_code_nxt   = r_key_code;
    w_break_nxt      = r_break;
    w_ext_nxt        = r_ext;
    w_keys_nxt       = r_keys;

    if (w_timeout) begin
      w_break_nxt = 1'b0;
      w_ext_nxt   = 1'b0;
    end

    if (w_frame_done) begin
      if (!w_frame_good) begin
        // Drop any half-seen prefix so the next sequence starts clean.
        w_parity_err_nxt = 1'b1;
        w_break_nxt      = 1'b0;
        w_ext_nxt        = 1'b0;
      end else begin
        w_key_valid_nxt = 1'b1;
        w_key_code_nxt  = r_shift;
        if (r_shift == c_BREAK) begin
          w_break_nxt = 1'b1;
        end else if (r_shift == c_EXTENDED) begin
          w_ext_nxt = 1'b1;
        end else begin
          // A key's level follows the break flag: release drives it back high.
          if (!r_ext) begin
            case (r_shift)
              8'h1D:   w_keys_nxt[3] = r_break;
              8'h1C:   w_keys_nxt[2] = r_break;
              8'h1B:   w_keys_nxt[1] = r_break;
              8'h23:   w_keys_nxt[0] = r_break;
              default: w_keys_nxt    = r_keys;
            endcase
          end
`ifdef PS2_ARROW_KEYS_EN
          else begin
            case (r_shift)
              8'h75:   w_keys_nxt[3] = r_break;
              8'h6B:   w_keys_nxt[2] = r_break;
              8'h72:   w_keys_nxt[1] = r_break;
              8'h74:   w_keys_nxt[0] = r_break;
              default: w_keys_nxt    = r_keys;
            endcase
          end
`endif
          w_break_nxt = 1'b0;
          w_ext_nxt   = 1'b0;
        end
      end
    end
  end

  assign w          = r_keys[3];
  assign a          = r_keys[2];
  assign s          = r_keys[1];
  assign d          = r_keys[0];
  assign key_valid  = r_key_valid;
  assign key_code   = r_key_code;
  assign parity_err = r_parity_err;

endmodule
`default_nettype wire

// File: tb/tb_ps2_wasd_receiver.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2_wasd_receiver
// Purpose  : Scoreboard bench for ps2_wasd_receiver. Stimulus pushes the
//            expected pulse (kind, code, key levels) into a queue; a monitor
//            pops and compares whenever key_valid or parity_err fires.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_wasd_receiver;

  localparam int TIMEOUT = 300;
  localparam int HALF    = 12;

  logic       clk;
  logic       reset;
  logic       ps2_clk;
  logic       ps2_data;
  logic       w, a, s, d;
  logic       key_valid;
  logic [7:0] key_code;
  logic       parity_err;

  ps2_wasd_receiver #(
    .SYNC_STAGES    (2),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .w          (w),
    .a          (a),
    .s          (s),
    .d          (d),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .parity_err (parity_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       good;
    logic [7:0] code;
    logic [3:0] keys;
  } ev_t;

  ev_t exp_q[$];
  int  n_cmp  = 0;
  int  n_fail = 0;

  // Reference state: key levels {w,a,s,d} active-low, plus prefix flags.
  logic [3:0] m_keys = 4'hF;
  logic       m_brk  = 1'b0;
  logic       m_ext  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Index of the key (3=w..0=d) a byte selects, or -1.
  function automatic int key_index(input logic [7:0] b, input logic ext);
    logic [7:0] plain [4];
    logic [7:0] arrow [4];
    plain = '{8'h23, 8'h1B, 8'h1C, 8'h1D};
    arrow = '{8'h74, 8'h72, 8'h6B, 8'h75};
    for (int i = 0; i < 4; i++) begin
      if (!ext && b == plain[i]) return i;
`ifdef PS2_ARROW_KEYS_EN
      if (ext && b == arrow[i]) return i;
`endif
    end
    return -1;
  endfunction

  task automatic model_frame(input logic [7:0] b, input logic good);
    ev_t e;
    int  k;
    if (!good) begin
      m_brk = 1'b0;
      m_ext = 1'b0;
    end else if (b == 8'hF0) begin
      m_brk = 1'b1;
    end else if (b == 8'hE0) begin
      m_ext = 1'b1;
    end else begin
      k = key_index(b, m_ext);
      if (k >= 0) m_keys[k] = m_brk;
      m_brk = 1'b0;
      m_ext = 1'b0;
    end
    e.good = good;
    e.code = good ? b : 8'h00;
    e.keys = m_keys;
    exp_q.push_back(e);
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk);
    ps2_data = b;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic bad_par, input logic bad_stop);
    logic p;
    p = (~^b) ^ bad_par;
    model_frame(b, !bad_par && !bad_stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(p);
    send_bit(~bad_stop);
    ps2_data = 1'b1;
    repeat (2 * HALF) @(negedge clk);
  endtask

  // Start bit plus nbits data bits, then the line goes quiet past the timeout.
  task automatic send_partial(input int nbits);
    send_bit(1'b0);
    for (int i = 0; i < nbits; i++) send_bit(1'($urandom_range(0, 1)));
    ps2_data = 1'b1;
    m_brk = 1'b0;
    m_ext = 1'b0;
    repeat (TIMEOUT + 10) @(negedge clk);
  endtask

  // Monitor: every output pulse is matched against the queue head.
  always @(negedge clk) begin
    ev_t e;
    if (reset && (key_valid || parity_err)) begin
      check("pulse_exclusive", {31'd0, key_valid & parity_err}, 32'd0);
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", {31'd0, key_valid}, 32'd2);
      end else begin
        e = exp_q.pop_front();
        check("pulse_kind", {31'd0, key_valid}, {31'd0, e.good});
        if (e.good) check("key_code", {24'd0, key_code}, {24'd0, e.code});
        check("keys_wasd", {28'd0, w, a, s, d}, {28'd0, e.keys});
      end
    end
  end

  task automatic check_keys(input string name, input logic [3:0] exp);
    check(name, {28'd0, w, a, s, d}, {28'd0, exp});
  endtask

  logic [7:0] pool [12];
  int         r;
  logic [7:0] b;

  initial begin
    pool = '{8'h1D, 8'h1C, 8'h1B, 8'h23, 8'hF0, 8'hF0, 8'hE0,
             8'h75, 8'h6B, 8'h72, 8'h74, 8'h00};
    reset    = 1'b0;
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    repeat (5) @(negedge clk);
    check_keys("reset_keys", 4'hF);
    check("reset_valid", {31'd0, key_valid}, 32'd0);
    check("reset_perr", {31'd0, parity_err}, 32'd0);
    check("reset_code", {24'd0, key_code}, 32'h00);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    check_keys("post_release_keys", 4'hF);

    // Make, then break, of W.
    send_byte(8'h1D, 1'b0, 1'b0);
    check_keys("w_held", 4'b0111);
    send_byte(8'hF0, 1'b0, 1'b0);
    send_byte(8'h1D, 1'b0, 1'b0);
    check_keys("w_released", 4'hF);

    // Wrong parity on A.
    send_byte(8'h1C, 1'b1, 1'b0);
    check_keys("a_after_bad_parity", 4'hF);

    // Aborted frame, then D must still decode.
    send_partial(4);
    send_byte(8'h23, 1'b0, 1'b0);
    check_keys("d_after_timeout", 4'b1110);
    check("code_23", {24'd0, key_code}, 32'h23);

    // Extended up-arrow.
    send_byte(8'hE0, 1'b0, 1'b0);
    send_byte(8'h75, 1'b0, 1'b0);
`ifdef PS2_ARROW_KEYS_EN
    check_keys("arrow_up", 4'b0110);
`else
    check_keys("arrow_up", 4'b1110);
`endif
    check("code_75", {24'd0, key_code}, 32'h75);

    // Randomised traffic.
    for (int n = 0; n < 90; n++) begin
      r = $urandom_range(0, 19);
      b = pool[$urandom_range(0, 11)];
      if (b == 8'h00) b = 8'($urandom);
      if (r == 0)      send_byte(b, 1'b1, 1'b0);
      else if (r == 1) send_byte(b, 1'b0, 1'b1);
      else if (r == 2) send_partial($urandom_range(1, 8));
      else             send_byte(b, 1'b0, 1'b0);
    end
    check_keys("random_end_keys", m_keys);

    // Reset in the middle of a frame.
    send_bit(1'b0);
    send_bit(1'b1);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_keys("midframe_reset_keys", 4'hF);
    check("midframe_reset_code", {24'd0, key_code}, 32'h00);
    m_keys = 4'hF;
    m_brk  = 1'b0;
    m_ext  = 1'b0;
    reset  = 1'b1;
    repeat (5) @(negedge clk);
    send_byte(8'h1B, 1'b0, 1'b0);
    check_keys("s_after_reset", 4'b1101);

    for (int i = 0; i < 1000 && exp_q.size() != 0; i++) @(negedge clk);
    check("queue_drained", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
